// File: rtl/seqgen_tx.sv
// Colour-sequence transmitter: plays a latched N-step r/g/b code sequence with start/advance strobes.
// Latency: go at edge 0 -> s in cycle 1, done in cycle 2 + N_STEPS*HOLD + (N_STEPS-1)*GAP (+ echo window).
// Backpressure: none; go is only sampled in IDLE and ignored for the rest of a run.
// Optional echo check of the detector's unlock output is enabled by defining SEQGEN_ECHO_CHECK_EN.
module seqgen_tx #(
    parameter int N_STEPS = 4,
    parameter int HOLD    = 2,
    parameter int GAP     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [2*N_STEPS-1:0]   seq,
`ifdef SEQGEN_ECHO_CHECK_EN
    input  logic                   u,
    output logic                   pass,
`endif
    output logic                   s,
    output logic                   r,
    output logic                   g,
    output logic                   b,
    output logic                   a,
    output logic                   busy,
    output logic                   done
);

    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SW   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [SW-1:0] LAST    = SW'(N_STEPS - 1);
`ifdef SEQGEN_ECHO_CHECK_EN
    // Two-cycle unlock window: counter runs 1 -> 0.
    localparam logic [CW-1:0] CHK_LD  = CW'(1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SYM,
        ST_GAP,
`ifdef SEQGEN_ECHO_CHECK_EN
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    state_t                 state_q;
    logic [2*N_STEPS-1:0]   shadow_q;
    logic [SW-1:0]          step_q;
    logic [SW-1:0]          step_inc;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             rgb_q;
    logic                   s_q;
    logic                   a_q;
    logic                   busy_q;
    logic                   done_q;
`ifdef SEQGEN_ECHO_CHECK_EN
    logic                   pass_q;
`endif

    // Code 00 is a deliberate blank: no colour, but the step still strobes a.
    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            2'b01:   decode = 3'b100;
            2'b10:   decode = 3'b010;
            2'b11:   decode = 3'b001;
            default: decode = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] code_at(input logic [2*N_STEPS-1:0] sh, input logic [SW-1:0] idx);
        code_at = sh[2*int'(idx) +: 2];
    endfunction

    assign step_inc = step_q + SW'(1);

    // Sequencer FSM; every output is computed one cycle ahead so it leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            rgb_q    <= 3'b000;
            s_q      <= 1'b0;
            a_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQGEN_ECHO_CHECK_EN
            pass_q   <= 1'b0;
`endif
        end else begin
            s_q    <= 1'b0;
            a_q    <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        shadow_q <= seq;
                        step_q   <= '0;
                        cnt_q    <= '0;
                        s_q      <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef SEQGEN_ECHO_CHECK_EN
                        pass_q   <= 1'b0;
`endif
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= HOLD_LD;
                    rgb_q   <= decode(code_at(shadow_q, step_q));
                    a_q     <= (HOLD == 1);
                    state_q <= ST_SYM;
                end
                ST_SYM: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        // Next cycle is the last hold cycle of this step.
                        a_q   <= (cnt_q == CW'(1));
                    end else begin
                        rgb_q <= 3'b000;
                        if (step_q == LAST) begin
`ifdef SEQGEN_ECHO_CHECK_EN
                            cnt_q   <= CHK_LD;
                            state_q <= ST_CHECK;
`else
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
`endif
                        end else begin
                            step_q <= step_inc;
                            if (GAP > 0) begin
                                cnt_q   <= GAP_LD;
                                state_q <= ST_GAP;
                            end else begin
                                // Back-to-back steps: reload hold and present next colour.
                                cnt_q   <= HOLD_LD;
                                rgb_q   <= decode(code_at(shadow_q, step_inc));
                                a_q     <= (HOLD == 1);
                                state_q <= ST_SYM;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        cnt_q   <= HOLD_LD;
                        rgb_q   <= decode(code_at(shadow_q, step_q));
                        a_q     <= (HOLD == 1);
                        state_q <= ST_SYM;
                    end
                end
`ifdef SEQGEN_ECHO_CHECK_EN
                ST_CHECK: begin
                    if (u) begin
                        pass_q  <= 1'b1;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign r    = rgb_q[2];
    assign g    = rgb_q[1];
    assign b    = rgb_q[0];
    assign a    = a_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SEQGEN_ECHO_CHECK_EN
    assign pass = pass_q;
`endif

endmodule

// File: tb/tb_seqgen_tx.sv
// Directed bench for seqgen_tx: default instance (HOLD=2, GAP=1) and a fast one (HOLD=1, GAP=0).
// Rows are {s,r,g,b,a,busy,done} per cycle; cycle c lies between clock edges c-1 and c.
// With SEQGEN_ECHO_CHECK_EN the echo window is inserted before done.
module tb_seqgen_tx;

    typedef logic [6:0] row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       go1, go2;
    logic [7:0] seq1, seq2;
    logic       s1, r1, g1, b1, a1, busy1, done1;
    logic       s2, r2, g2, b2, a2, busy2, done2;
`ifdef SEQGEN_ECHO_CHECK_EN
    logic       u1, u2, pass1, pass2;
    localparam int SH_U  = 1;   // window closed by u in its first cycle
    localparam int SH_NU = 2;   // window expires
`else
    localparam int SH_U  = 0;
    localparam int SH_NU = 0;
`endif

    seqgen_tx #(.N_STEPS(4), .HOLD(2), .GAP(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .go(go1), .seq(seq1),
`ifdef SEQGEN_ECHO_CHECK_EN
        .u(u1), .pass(pass1),
`endif
        .s(s1), .r(r1), .g(g1), .b(b1), .a(a1), .busy(busy1), .done(done1)
    );

    seqgen_tx #(.N_STEPS(4), .HOLD(1), .GAP(0)) dut_fast (
        .clk(clk), .rst_n(rst_n), .go(go2), .seq(seq2),
`ifdef SEQGEN_ECHO_CHECK_EN
        .u(u2), .pass(pass2),
`endif
        .s(s2), .r(r2), .g(g2), .b(b2), .a(a2), .busy(busy2), .done(done2)
    );

    // seq 8'h6D = red, blue, green, red
    localparam row_t T6D [0:14] = '{
        7'b0000000, 7'b1000010, 7'b0100010, 7'b0100110, 7'b0000010,
        7'b0001010, 7'b0001110, 7'b0000010, 7'b0010010, 7'b0010110,
        7'b0000010, 7'b0100010, 7'b0100110, 7'b0000001, 7'b0000000 };
    // seq 8'h61 = red, blank, green, red (blank step strobes a with no colour)
    localparam row_t T61 [0:14] = '{
        7'b0000000, 7'b1000010, 7'b0100010, 7'b0100110, 7'b0000010,
        7'b0000010, 7'b0000110, 7'b0000010, 7'b0010010, 7'b0010110,
        7'b0000010, 7'b0100010, 7'b0100110, 7'b0000001, 7'b0000000 };
    // HOLD=1 GAP=0, seq 8'h6D with go held: restart s in the cycle after the IDLE cycle
    localparam row_t TFA [0:14] = '{
        7'b0000000, 7'b1000010, 7'b0100110, 7'b0001110, 7'b0010110,
        7'b0100110, 7'b0000001, 7'b0000000, 7'b1000010, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000 };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic row_t pack1();
        return {s1, r1, g1, b1, a1, busy1, done1};
    endfunction

    function automatic row_t pack2();
        return {s2, r2, g2, b2, a2, busy2, done2};
    endfunction

    function automatic row_t base_row(input int tbl, input int c);
        case (tbl)
            0:       return T6D[c];
            1:       return T61[c];
            default: return TFA[c];
        endcase
    endfunction

    // Cycles from dcyc on are pushed back by 'shift' busy-only echo-window cycles.
    function automatic row_t expect_row(input int tbl, input int c, input int dcyc, input int shift);
        if (shift == 0 || c < dcyc)  return base_row(tbl, c);
        if (c < dcyc + shift)        return 7'b0000010;
        return base_row(tbl, c - shift);
    endfunction

    // One run: go at edge 0, rows sampled at each negedge, inputs changed at negedges.
    task automatic play(input int inst, input logic [7:0] sv, input int tbl, input int ncyc,
                        input int dcyc, input int shift, input bit u_on, input bit disturb,
                        input bit hold, input bit exp_pass, input string name);
        row_t got;
        @(negedge clk);
        if (inst == 1) begin seq1 = sv; go1 = 1'b1; end
        else           begin seq2 = sv; go2 = 1'b1; end
        for (int c = 1; c <= ncyc + shift; c++) begin
            @(negedge clk);
            got = (inst == 1) ? pack1() : pack2();
            check_eq($sformatf("%s_c%0d", name, c), 32'(got), 32'(expect_row(tbl, c, dcyc, shift)));
`ifdef SEQGEN_ECHO_CHECK_EN
            if (inst == 1 && c == 1) check_eq($sformatf("%s_pass_clr", name), 32'(pass1), 32'd0);
            u1 = (inst == 1) && u_on && (c == dcyc);
            u2 = (inst == 2) && u_on && (c == dcyc);
`endif
            if (inst == 1) go1 = disturb ? (c == 3 || c == 7) : hold;
            else           go2 = hold;
            if (disturb && c == 5) seq1 = 8'h00;
        end
        go1 = 1'b0;
        go2 = 1'b0;
`ifdef SEQGEN_ECHO_CHECK_EN
        u1 = 1'b0;
        u2 = 1'b0;
        if (inst == 1) check_eq($sformatf("%s_pass", name), 32'(pass1), 32'(exp_pass));
`endif
        // Let any restarted run drain before the next test.
        for (int k = 0; k < 60; k++) begin
            if (inst == 1 && !busy1 && !done1) break;
            if (inst == 2 && !busy2 && !done2) break;
            @(negedge clk);
        end
        check_eq($sformatf("%s_drained", name), 32'((inst == 1) ? busy1 : busy2), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        go1 = 1'b0; go2 = 1'b0; seq1 = 8'h00; seq2 = 8'h00;
`ifdef SEQGEN_ECHO_CHECK_EN
        u1 = 1'b0; u2 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_def", 32'(pack1()), 32'd0);
        check_eq("reset_fast", 32'(pack2()), 32'd0);
`ifdef SEQGEN_ECHO_CHECK_EN
        check_eq("reset_pass", 32'(pass1), 32'd0);
`endif
        rst_n = 1'b1;

        // Asynchronous reset mid-SYM
        @(negedge clk);
        seq1 = 8'h6D; go1 = 1'b1;
        @(negedge clk);
        go1 = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_r", 32'(r1), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", 32'(pack1()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_idle1", 32'(pack1()), 32'd0);
        @(negedge clk);
        check_eq("rst_idle2", 32'(pack1()), 32'd0);

        play(1, 8'h6D, 0, 14, 13, SH_U,  1'b1, 1'b0, 1'b0, 1'b1, "t2_6d");
        play(1, 8'h6D, 0, 14, 13, SH_U,  1'b1, 1'b1, 1'b0, 1'b1, "t3_ignore");
        play(1, 8'h61, 1, 14, 13, SH_NU, 1'b0, 1'b0, 1'b0, 1'b0, "t5_blank");
        play(2, 8'h6D, 2, 8,  6,  SH_U,  1'b1, 1'b0, 1'b1, 1'b0, "t4_fast");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
